alu_fu_pipe: RTL and testbench
==============================

Name: alu_fu_pipe

Overview:
- Parametrised, pipelined integer ALU functional unit for the out-of-order backend; sits between the ALU reservation station and the CDB arbiter.
- Accepts one tagged operation per cycle through a valid/ready handshake and carries it through STAGES register stages.
- Presents the result with its ROB tag on an output valid/ready handshake.
- Supports backpressure and branch-mispredict flush.
- Adds set-less-than (signed/unsigned) and an illegal-op flag over the base ALU.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, 8..64.
STAGES, 2, pipeline depth / latency in cycles; legal range 1..4.
TAG_W, 5, ROB tag width in bits.

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of every in-flight op
in_valid  in  1  upstream has an op
in_ready  out  1  unit can accept this cycle
in_op  in  4  operation select
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_tag  in  TAG_W  ROB tag of the op
out_valid  out  1  result available
out_ready  in  1  CDB grants the result
out_result  out  WIDTH  result
out_tag  out  TAG_W  tag travelling with the result
out_illegal  out  1  op code was undefined

Behaviour:
- Op encoding:
  - 0 add; 1 sub; 2 sll; 3 srl; 4 sra; 5 xor; 6 or; 7 and.
  - 8 slt: signed A<B; result 1, zero-extended.
  - 9 sltu: unsigned A<B; result 1, zero-extended.
  - 10..15 illegal: result 0, illegal=1.
- Shift amount is b[log2(WIDTH)-1:0]; upper bits of b are ignored.
- add/sub wrap modulo 2^WIDTH; no overflow flag.
- Computation is combinational ahead of stage 1. Stages 2..STAGES only carry {valid, result, tag, illegal}. Output ports are driven by the final-stage registers.
- Stage advance rules:
  - Stage k register loads when stage k is empty or stage k itself is advancing (elastic pipeline, no bubbles under stall).
  - The final stage advances when out_valid && out_ready.
- in_ready = stage 1 empty || stage 1 advancing. This is combinational from out_ready and the valid bits, not from in_valid.
- Accept occurs when in_valid && in_ready.
- Latency: an op accepted in cycle N shows out_valid=1 in cycle N+STAGES if no stall occurs.
- Throughput is 1 op/cycle while out_ready is held high.
- Capacity is STAGES ops. With out_ready low, exactly STAGES ops are accepted, then in_ready=0.
- While out_valid=1 and out_ready=0, out_result, out_tag and out_illegal hold stable.
- flush:
  - All stage valid bits clear at the next edge, and out_valid=0 the next cycle.
  - An op presented in the same cycle as flush is not accepted, even when in_ready=1.
  - A handshake completing on the output in the flush cycle counts as delivered.
- Reset (async assert, released on clock): all valid bits, result/tag/illegal registers and out_illegal = 0; out_valid=0; in_ready=1 after reset.
- Reset mid-operation discards all in-flight ops with no output.
- Data registers in empty stages hold their last value; consumers must qualify them with out_valid.

Test Plan:
1. STAGES=2, out_ready=1; issue add a=0xFFFFFFFF b=1 tag=3 at cycle 0 -> out_valid at cycle 2, out_result=0x00000000, out_tag=3, out_illegal=0.
2. Back-to-back sra a=0x80000000 b=0x24, srl with the same operands, slt a=0xFFFFFFFE b=1, sltu with the same operands -> 0xF8000000, 0x08000000, 1, 0 on four consecutive cycles, tags in issue order.
3. out_ready=0 with continuous in_valid -> exactly 2 ops accepted, then in_ready=0. Outputs hold stable for 5 cycles. Raising out_ready drains both ops on consecutive cycles with no loss.
4. Two ops in flight, pulse flush together with in_valid -> no out_valid in any following cycle; the same-cycle op is not accepted; in_ready=1 afterwards.
5. op=12 a=5 b=7 -> out_result=0, out_illegal=1. Assert rst asynchronously mid-flight -> out_valid drops immediately, no stale output after release.
6. Rebuild with WIDTH=64, STAGES=1: sll a=1 b=63 -> 0x8000000000000000 at cycle N+1; b=64 shifts by 0 -> 1.

Source files
------------

// File: rtl/alu_fu_pipe.sv
// alu_fu_pipe: pipelined integer ALU functional unit with tagged
// valid/ready handshakes, elastic stall and mispredict flush.
module alu_fu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_ill;
    logic              accept;
    logic              full;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] ill_q;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] vin;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

    assign shamt = in_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (in_op)
            4'd0:    alu_res = in_a + in_b;
            4'd1:    alu_res = in_a - in_b;
            4'd2:    alu_res = in_a << shamt;
            4'd3:    alu_res = in_a >> shamt;
            4'd4:    alu_res = $signed(in_a) >>> shamt;
            4'd5:    alu_res = in_a ^ in_b;
            4'd6:    alu_res = in_a | in_b;
            4'd7:    alu_res = in_a & in_b;
            4'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            4'd9:    alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
            default: alu_ill = 1'b1;
        endcase
    end

    // Stage k can load unless it and every stage after it are full
    // while the CDB is not granting.
    always_comb begin
        ld   = '0;
        full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full  = full & vld_q[k];
            ld[k] = out_ready | ~full;
        end
    end

    assign in_ready = ld[0];
    assign accept   = in_valid & ld[0] & ~flush;

    always_comb begin
        vin    = '0;
        vin[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = vld_q[k-1];
        end
        vld_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k] = flush ? 1'b0 : (ld[k] ? vin[k] : vld_q[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ill_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            if (ld[0] && vin[0]) begin
                res_q[0] <= alu_res;
                tag_q[0] <= in_tag;
                ill_q[0] <= alu_ill;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld[k] && vin[k]) begin
                    res_q[k] <= res_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                    ill_q[k] <= ill_q[k-1];
                end
            end
        end
    end

    assign out_valid   = vld_q[STAGES-1];
    assign out_result  = res_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];
    assign out_illegal = ill_q[STAGES-1];

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Directed bench for alu_fu_pipe: default 32-bit/2-stage build plus a
// 64-bit/1-stage build for wide shift amounts.
module tb_alu_fu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    logic        w_flush;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [3:0]  w_in_op;
    logic [63:0] w_in_a;
    logic [63:0] w_in_b;
    logic [4:0]  w_in_tag;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_result;
    logic [4:0]  w_out_tag;
    logic        w_out_illegal;

    int checks = 0;
    int failures = 0;
    int acc;

    always #5 clk = ~clk;

    alu_fu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_illegal(out_illegal)
    );

    alu_fu_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
        .in_a(w_in_a), .in_b(w_in_b), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_result(w_out_result), .out_tag(w_out_tag),
        .out_illegal(w_out_illegal)
    );

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    logic [3:0]  t_op  [9];
    logic [31:0] t_a   [9];
    logic [31:0] t_b   [9];
    logic [31:0] t_exp [9];

    initial begin
        t_op[0] = 4'd4; t_a[0] = 32'h8000_0000; t_b[0] = 32'h24; t_exp[0] = 32'hF800_0000;
        t_op[1] = 4'd3; t_a[1] = 32'h8000_0000; t_b[1] = 32'h24; t_exp[1] = 32'h0800_0000;
        t_op[2] = 4'd8; t_a[2] = 32'hFFFF_FFFE; t_b[2] = 32'h1;  t_exp[2] = 32'h1;
        t_op[3] = 4'd9; t_a[3] = 32'hFFFF_FFFE; t_b[3] = 32'h1;  t_exp[3] = 32'h0;
        t_op[4] = 4'd1; t_a[4] = 32'h3;         t_b[4] = 32'h5;  t_exp[4] = 32'hFFFF_FFFE;
        t_op[5] = 4'd5; t_a[5] = 32'hF0F0_F0F0; t_b[5] = 32'hFF00_FF00; t_exp[5] = 32'h0FF0_0FF0;
        t_op[6] = 4'd6; t_a[6] = 32'hF0F0_F0F0; t_b[6] = 32'hFF00_FF00; t_exp[6] = 32'hFFF0_FFF0;
        t_op[7] = 4'd7; t_a[7] = 32'hF0F0_F0F0; t_b[7] = 32'hFF00_FF00; t_exp[7] = 32'hF000_F000;
        t_op[8] = 4'd2; t_a[8] = 32'h1;         t_b[8] = 32'h21; t_exp[8] = 32'h2;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_op = '0;
        w_in_a = '0; w_in_b = '0; w_in_tag = '0; w_out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", out_result, 32'h0);
        chk("rst_tag", out_tag, 5'd0);
        chk("rst_illegal", out_illegal, 1'b0);
        chk("rst64_valid", w_out_valid, 1'b0);

        // add wraps, latency two cycles
        drive(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3);
        step();
        in_valid = 1'b0;
        chk("add_lat1_valid", out_valid, 1'b0);
        step();
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", out_result, 32'h0);
        chk("add_tag", out_tag, 5'd3);
        chk("add_illegal", out_illegal, 1'b0);
        step();
        chk("add_drained", out_valid, 1'b0);

        // back-to-back stream
        for (int i = 0; i < 10; i++) begin
            if (i < 9) drive(t_op[i], t_a[i], t_b[i], 5'(4 + i));
            else in_valid = 1'b0;
            step();
            if (i >= 1) begin
                chk("b2b_valid", out_valid, 1'b1);
                chk("b2b_result", out_result, t_exp[i-1]);
                chk("b2b_tag", out_tag, 5'(3 + i));
            end
        end
        step();
        chk("b2b_drained", out_valid, 1'b0);

        // backpressure: capacity two, stable hold, lossless drain
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            drive(4'd0, 32'(acc), 32'd100, 5'(20 + acc));
            #1;
            if (in_ready) acc++;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_result", out_result, 32'd100);
            chk("bp_hold_tag", out_tag, 5'd20);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain2_valid", out_valid, 1'b1);
        chk("bp_drain2_result", out_result, 32'd101);
        chk("bp_drain2_tag", out_tag, 5'd21);
        step();
        chk("bp_drain_empty", out_valid, 1'b0);

        // flush with same-cycle op
        out_ready = 1'b0;
        drive(4'd0, 32'd1, 32'd1, 5'd1);
        step();
        drive(4'd0, 32'd2, 32'd2, 5'd2);
        step();
        chk("fl_pre_valid", out_valid, 1'b1);
        drive(4'd0, 32'd3, 32'd3, 5'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_in_ready_same", in_ready, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_in_ready_after", in_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk("fl_no_valid", out_valid, 1'b0);
            step();
        end

        // illegal op
        drive(4'd12, 32'd5, 32'd7, 5'd9);
        step();
        in_valid = 1'b0;
        step();
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_result", out_result, 32'h0);
        chk("ill_flag", out_illegal, 1'b1);
        chk("ill_tag", out_tag, 5'd9);

        // async reset mid-flight
        drive(4'd0, 32'd10, 32'd0, 5'd10);
        step();
        drive(4'd0, 32'd11, 32'd0, 5'd11);
        step();
        in_valid = 1'b0;
        chk("rstm_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstm_valid_drop", out_valid, 1'b0);
        chk("rstm_in_ready", in_ready, 1'b1);
        chk("rstm_illegal", out_illegal, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rstm_no_stale", out_valid, 1'b0);
            step();
        end

        // 64-bit, single stage
        w_in_valid = 1'b1;
        w_in_op = 4'd2;
        w_in_a = 64'd1;
        w_in_b = 64'd63;
        w_in_tag = 5'd1;
        step();
        chk("w_sll63_valid", w_out_valid, 1'b1);
        chk("w_sll63_result", w_out_result, 64'h8000_0000_0000_0000);
        chk("w_sll63_tag", w_out_tag, 5'd1);
        w_in_b = 64'd64;
        w_in_tag = 5'd2;
        step();
        w_in_valid = 1'b0;
        chk("w_sll64_result", w_out_result, 64'h1);
        chk("w_sll64_tag", w_out_tag, 5'd2);
        step();
        chk("w_drained", w_out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
